key10_encoder: RTL and testbench
================================

KEY10_ENCODER -- requirements
Module: key10_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000, number of consecutive stable synchronized samples required to accept a press or release; legal range 2..65535.
REQ-002 i_clk  input  1  single clock for all sequential logic.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_keys  input  10  raw key levels, bit k high = key k pressed, asynchronous to i_clk.
REQ-005 o_code  output  4  accepted key code, key k -> k+1 (1..10), 0 = no key; feeds the 4-to-10 one-hot decoder.
REQ-006 o_valid  output  1  level, high while an accepted key is held (states HELD and DEB_REL).
REQ-007 o_press  output  1  one-cycle pulse on acceptance of a new press.
REQ-008 o_release  output  1  one-cycle pulse on acceptance of a release.
REQ-009 o_multi  output  1  registered flag, high while two or more synchronized key bits are set.

Function
REQ-010 i_keys SHALL pass through a two-flop synchronizer; all decisions SHALL use the synchronized vector s.
REQ-011 FSM states SHALL be IDLE, DEB_PRESS, HELD, DEB_REL.
REQ-012 IDLE: s exactly one-hot -> capture s as candidate, counter=0, go DEB_PRESS; s zero or multi-hot -> stay IDLE.
REQ-013 DEB_PRESS: s==candidate and counter==DEBOUNCE_CYCLES-1 -> HELD, o_code=candidate index+1, o_valid=1, o_press=1 for one cycle; s==candidate otherwise -> counter+1; s!=candidate -> IDLE, no outputs change.
REQ-014 HELD: s==candidate -> stay; s!=candidate -> DEB_REL, counter=0.
REQ-015 DEB_REL: s==candidate -> HELD, no o_press pulse; s!=candidate and counter==DEBOUNCE_CYCLES-1 -> IDLE, o_code=0, o_valid=0, o_release=1 for one cycle; otherwise counter+1.
REQ-016 o_code and o_valid SHALL remain constant through DEB_REL until release is accepted.
REQ-017 Latency: i_keys stable from edge 0 -> o_press high in the cycle following edge DEBOUNCE_CYCLES+3.
REQ-018 A second key added while HELD SHALL be treated as s!=candidate (release path); no key change is reported without an intervening release.
REQ-019 o_press and o_release SHALL never be high in the same cycle; all outputs SHALL be registered.
REQ-020 Counter width SHALL be ceil(log2(DEBOUNCE_CYCLES)); the counter SHALL never wrap.
REQ-021 o_multi SHALL update every cycle from s, independent of FSM state.

Reset
REQ-022 i_rst_n low SHALL asynchronously force state IDLE, synchronizer flops 0, counter 0, candidate 0, and all outputs 0.
REQ-023 Reset asserted mid-press or mid-hold SHALL produce no o_release pulse; after deassertion a still-pressed key SHALL be re-debounced from IDLE.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding, KEY_COUNT=10, CODE_W=4, and CODE_NONE=0.
REQ-025 The synchronizer SHALL be a separate sub-module key_sync (parameterized width, async active-low reset); one-hot test and index encode stay inside key10_encoder.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Reset, then i_keys=10'h000 for 20 cycles -> o_code=0, o_valid=0, no pulses.
REQ-027 i_keys=10'h008 from edge 0 held -> o_press single pulse after edge 7, o_code=4, o_valid=1; release to 0 -> o_release single pulse 7 edges later, o_code=0.
REQ-028 i_keys=10'h200 glitching low for 1 cycle every 3 cycles -> no o_press; then stable -> o_code=10.
REQ-029 i_keys=10'h003 -> o_multi=1 after 3 edges, no o_press, o_code=0; then 10'h001 stable -> o_code=1, o_multi=0.
REQ-030 Key 0 held (o_code=1), 2-cycle dropout in HELD -> return to HELD, no o_release, no second o_press.
REQ-031 Key 5 held, i_rst_n pulsed low -> outputs 0 immediately, no o_release; after deassertion o_press after edge 7 with o_code=6.

Source files
------------

// File: rtl/key10_encoder_pkg.sv
// Shared types and constants for the 10-key debounced encoder.
// Holds the FSM encoding, key/code widths and the one-hot helpers.
package key10_encoder_pkg;

    localparam int KEY_COUNT = 10;
    localparam int CODE_W    = 4;
    localparam logic [CODE_W-1:0] CODE_NONE = '0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DEB_PRESS = 2'd1,
        ST_HELD      = 2'd2,
        ST_DEB_REL   = 2'd3
    } state_t;

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    function automatic logic is_onehot(input logic [KEY_COUNT-1:0] v);
        return (v != '0) && ((v & (v - KEY_COUNT'(1))) == '0);
    endfunction

    function automatic logic is_multi(input logic [KEY_COUNT-1:0] v);
        return (v & (v - KEY_COUNT'(1))) != '0;
    endfunction

    // Key k maps to code k+1 so that zero stays free for "no key".
    function automatic logic [CODE_W-1:0] encode_key(input logic [KEY_COUNT-1:0] v);
        logic [CODE_W-1:0] code;
        code = CODE_NONE;
        for (int k = 0; k < KEY_COUNT; k++) begin
            if (v[k]) begin
                code = CODE_W'(k + 1);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/key10_encoder_sync.sv
// Two-flop synchronizer bringing the raw key levels into the i_clk domain.
module key_sync #(
    parameter int WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule

// File: rtl/key10_encoder.sv
// Debounced 10-key encoder: accepts a single held key, reports its code,
// and pulses on accepted press and release.
//
// state        | meaning
// ST_IDLE      | no key accepted, waiting for a one-hot sample
// ST_DEB_PRESS | candidate seen, counting stable samples before acceptance
// ST_HELD      | key accepted, code and valid driven
// ST_DEB_REL   | candidate gone, counting samples before accepting release
module key10_encoder
    import key10_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [KEY_COUNT-1:0] i_keys,
    output logic [CODE_W-1:0]    o_code,
    output logic                 o_valid,
    output logic                 o_press,
    output logic                 o_release,
    output logic                 o_multi
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_COUNT-1:0] keys_s;
    logic [KEY_COUNT-1:0] cand_q;
    logic [CNT_W-1:0]     cnt_q;
    state_t               state_q;
    logic [CODE_W-1:0]    code_q;
    logic                 valid_q;
    logic                 press_q;
    logic                 release_q;
    logic                 multi_q;
    logic                 match;

    key_sync #(
        .WIDTH(KEY_COUNT)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_async(i_keys),
        .o_sync (keys_s)
    );

    assign match = (keys_s == cand_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            code_q    <= CODE_NONE;
            valid_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            multi_q   <= is_multi(keys_s);
            case (state_q)
                ST_IDLE: begin
                    if (is_onehot(keys_s)) begin
                        cand_q  <= keys_s;
                        cnt_q   <= '0;
                        state_q <= ST_DEB_PRESS;
                    end
                end
                ST_DEB_PRESS: begin
                    if (!match) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_HELD;
                        code_q  <= encode_key(cand_q);
                        valid_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    // Any deviation, including an extra key, starts the release path.
                    if (!match) begin
                        state_q <= ST_DEB_REL;
                        cnt_q   <= '0;
                    end
                end
                ST_DEB_REL: begin
                    if (match) begin
                        state_q <= ST_HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= ST_IDLE;
                        code_q    <= CODE_NONE;
                        valid_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_code    = code_q;
    assign o_valid   = valid_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_multi   = multi_q;

endmodule

// File: tb/tb_key10_encoder.sv
// Bench for key10_encoder with DEBOUNCE_CYCLES=4: directed scenarios plus
// randomized key patterns compared against a run-length reference model.
module tb_key10_encoder;

    localparam int DEB = 4;

    logic       clk;
    logic       rst_n;
    logic [9:0] keys;
    logic [3:0] o_code;
    logic       o_valid;
    logic       o_press;
    logic       o_release;
    logic       o_multi;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [9:0] m_s1, m_s2, m_cand;
    bit         m_held, m_try;
    int         m_streak, m_away;
    logic [3:0] m_code;
    logic       m_valid, m_press, m_rel, m_multi;

    int tick_n, n_press, n_rel, press_at, rel_at;

    key10_encoder #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_keys   (keys),
        .o_code   (o_code),
        .o_valid  (o_valid),
        .o_press  (o_press),
        .o_release(o_release),
        .o_multi  (o_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] key_code(input logic [9:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int k = 0; k < 10; k++) if (v == (10'd1 << k)) c = 4'(k + 1);
        return c;
    endfunction

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_cand = '0;
        m_held = 0; m_try = 0; m_streak = 0; m_away = 0;
        m_code = '0; m_valid = 0; m_press = 0; m_rel = 0; m_multi = 0;
    endtask

    // A press is accepted once DEB+1 consecutive synchronized samples equal the
    // same single key, counted from a sample seen while not attempting; a release
    // once DEB+1 consecutive samples differ from the held key.
    task automatic model_step(input logic [9:0] k);
        logic [9:0] s;
        if (!rst_n) begin
            model_clear();
        end else begin
            s = m_s2;
            m_press = 0;
            m_rel = 0;
            m_multi = ($countones(s) >= 2);
            if (!m_held) begin
                if (m_try && s == m_cand) begin
                    m_streak++;
                    if (m_streak == DEB + 1) begin
                        m_held = 1; m_try = 0; m_away = 0;
                        m_code = key_code(s); m_valid = 1; m_press = 1;
                    end
                end else if (m_try) begin
                    m_try = 0;
                end else if ($countones(s) == 1) begin
                    m_try = 1; m_cand = s; m_streak = 1;
                end
            end else begin
                if (s == m_cand) begin
                    m_away = 0;
                end else begin
                    m_away++;
                    if (m_away == DEB + 1) begin
                        m_held = 0; m_code = 4'd0; m_valid = 0; m_rel = 1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = k;
        end
    endtask

    task automatic clear_counts();
        tick_n = 0; n_press = 0; n_rel = 0; press_at = -1; rel_at = -1;
    endtask

    task automatic tick(input logic [9:0] k);
        keys = k;
        @(posedge clk);
        @(negedge clk);
        model_step(k);
        tick_n++;
        chk("code", 16'(o_code), 16'(m_code));
        chk("valid", 16'(o_valid), 16'(m_valid));
        chk("press", 16'(o_press), 16'(m_press));
        chk("release", 16'(o_release), 16'(m_rel));
        chk("multi", 16'(o_multi), 16'(m_multi));
        if (o_press) begin n_press++; press_at = tick_n; end
        if (o_release) begin n_rel++; rel_at = tick_n; end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_code"}, 16'(o_code), 16'd0);
        chk({tag, "_valid"}, 16'(o_valid), 16'd0);
        chk({tag, "_press"}, 16'(o_press), 16'd0);
        chk({tag, "_release"}, 16'(o_release), 16'd0);
        chk({tag, "_multi"}, 16'(o_multi), 16'd0);
    endtask

    task automatic pulse_reset(input int low_ticks, input logic [9:0] k);
        rst_n = 1'b0;
        #1;
        model_clear();
        chk_all_zero("rst_async");
        for (int i = 0; i < low_ticks; i++) tick(k);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [9:0] v;
        int len;
        int kind;

        model_clear();
        clear_counts();
        rst_n = 1'b0;
        keys  = '0;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // idle with no keys
        clear_counts();
        repeat (20) tick(10'h000);
        chk("idle_press_cnt", 16'(n_press), 16'd0);
        chk("idle_rel_cnt", 16'(n_rel), 16'd0);

        // key 3 press and release latency
        clear_counts();
        repeat (12) tick(10'h008);
        chk("k3_press_cnt", 16'(n_press), 16'd1);
        chk("k3_press_at", 16'(press_at), 16'd7);
        chk("k3_code", 16'(o_code), 16'd4);
        chk("k3_valid", 16'(o_valid), 16'd1);
        clear_counts();
        repeat (10) tick(10'h000);
        chk("k3_rel_cnt", 16'(n_rel), 16'd1);
        chk("k3_rel_at", 16'(rel_at), 16'd7);
        chk("k3_code_rel", 16'(o_code), 16'd0);

        // key 9 glitching low every third cycle never settles
        clear_counts();
        repeat (6) begin
            tick(10'h200); tick(10'h200); tick(10'h000);
        end
        chk("glitch_press_cnt", 16'(n_press), 16'd0);
        repeat (12) tick(10'h200);
        chk("k9_press_cnt", 16'(n_press), 16'd1);
        chk("k9_code", 16'(o_code), 16'd10);
        repeat (10) tick(10'h000);

        // two keys together are flagged and never accepted
        clear_counts();
        repeat (2) tick(10'h003);
        chk("multi_early", 16'(o_multi), 16'd0);
        tick(10'h003);
        chk("multi_set", 16'(o_multi), 16'd1);
        repeat (10) tick(10'h003);
        chk("multi_press_cnt", 16'(n_press), 16'd0);
        chk("multi_code", 16'(o_code), 16'd0);
        repeat (12) tick(10'h001);
        chk("k0_code", 16'(o_code), 16'd1);
        chk("k0_multi", 16'(o_multi), 16'd0);

        // short dropout while held is absorbed
        clear_counts();
        tick(10'h000); tick(10'h000);
        repeat (10) tick(10'h001);
        chk("dropout_rel_cnt", 16'(n_rel), 16'd0);
        chk("dropout_press_cnt", 16'(n_press), 16'd0);
        chk("dropout_code", 16'(o_code), 16'd1);
        repeat (10) tick(10'h000);

        // reset while key 5 is held
        clear_counts();
        repeat (12) tick(10'h020);
        chk("k5_code", 16'(o_code), 16'd6);
        clear_counts();
        pulse_reset(2, 10'h020);
        chk("rst_rel_cnt", 16'(n_rel), 16'd0);
        clear_counts();
        repeat (12) tick(10'h020);
        chk("k5_repress_at", 16'(press_at), 16'd7);
        chk("k5_recode", 16'(o_code), 16'd6);
        chk("k5_rst_rel_cnt", 16'(n_rel), 16'd0);

        // randomized key patterns against the model
        for (int seg = 0; seg < 400; seg++) begin
            kind = int'($urandom_range(0, 99));
            if (kind < 25)      v = 10'h000;
            else if (kind < 75) v = 10'd1 << $urandom_range(0, 9);
            else if (kind < 90) v = (10'd1 << $urandom_range(0, 9)) | (10'd1 << $urandom_range(0, 9));
            else                v = 10'($urandom);
            len = int'($urandom_range(1, 10));
            if ($urandom_range(0, 99) < 2) begin
                pulse_reset(1, v);
            end
            for (int i = 0; i < len; i++) tick(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
